// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
//
// Byte FIFO plus send sequencer that sits directly in front of a UART
// transmitter. A host-side writer pushes bytes in bursts. The sequencer hands
// them to the transmitter one frame at a time, driving its data-valid/byte
// inputs and pacing itself on the transmitter's active/done status.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  log2(DEPTH), pointer width
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst           synchronous, active-high reset
//   i_Wr_En       write strobe; byte captured when high and o_Full is low
//   i_Wr_Byte     byte to enqueue
//   o_Full        queue holds DEPTH bytes
//   o_Empty       queue holds no bytes
//   o_Count       bytes queued (0..DEPTH), excluding the byte in flight
//   o_Overflow    one-cycle pulse after a write was refused because full
//   o_DV          to transmitter data-valid; one-cycle pulse per byte
//   o_Byte        to transmitter data; held from one o_DV to the next
//   i_Sig_Active  from transmitter; a frame is on the wire
//   i_Sig_Done    from transmitter; one-cycle pulse at end of stop bit
//   o_Busy        sequencer is not idle
// ----------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    // Host-side write port
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    // Transmitter-side interface
    output logic              o_DV,
    output logic [7:0]        o_Byte,
    input  logic              i_Sig_Active,
    input  logic              i_Sig_Done,
    output logic              o_Busy
);

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitDone = 2'd1,
        StGap      = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Storage and bookkeeping registers
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q, overflow_d;
    logic              dv_q,  dv_d;
    logic [7:0]        byte_q, byte_d;
    state_e            state_q, state_d;

    logic full;
    logic empty;
    logic wr_accept;
    logic launch;
    logic pop;

    // Count register is the only source of full/empty. A write is refused
    // whenever full, even if a pop frees a slot on the same edge.
    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign wr_accept = i_Wr_En && !full;

    // Start a frame only when idle, something is queued and the line is quiet.
    // The active check keeps us off a frame that predates our own reset.
    assign launch = (state_q == StIdle) && !empty && !i_Sig_Active;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // i_Sig_Done is deliberately ignored here.
                if (launch) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (i_Sig_Done) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                // One spare cycle while the transmitter runs its cleanup.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        pop    = 1'b0;
        dv_d   = 1'b0;
        byte_d = byte_q;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    pop    = 1'b1;
                    dv_d   = 1'b1;
                    byte_d = mem_q[rd_ptr_q];
                end
            end
            StWaitDone: begin
                // dv_d stays low, so o_DV is high for exactly one cycle.
            end
            StGap: begin
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointer / count next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = i_Wr_En && full;

        // Pointers are exactly ADDR_W bits, so DEPTH-1 wraps to 0 on its own.
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte storage. Not reset: only slots written since reset are ever
    // read, because count gates every pop. No read-during-write bypass;
    // a pop can only happen when count is non-zero, so it never targets
    // the slot being written on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_DV       = dv_q;
    assign o_Byte     = byte_q;
    assign o_Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_queue.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Directed bench for uart_tx_queue. A small transmitter model answers each
// o_DV with a fixed-length frame (active high, then a one-cycle done pulse)
// and records every byte it accepts.
// ----------------------------------------------------------------------------
module tb_uart_tx_queue;

    localparam int FRAME   = 6;
    localparam int TIMEOUT = 3000;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       full, empty, overflow, dv, busy;
    logic [4:0] count;
    logic [7:0] obyte;
    logic       sig_active;

    // Transmitter model state
    logic       hold      = 1'b0;
    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;
    int         tx_cnt    = 0;
    logic [7:0] rx_q [$];
    int         dv_pulses = 0;
    int         dv_wide   = 0;
    int         dv_busy   = 0;
    int         cyc       = 0;
    int         done_cyc  = -100;
    int         last_gap  = 0;
    logic       dv_prev   = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    assign sig_active = tx_active | hold;

    always #5 clk = ~clk;

    uart_tx_queue #(
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_Wr_En      (wr_en),
        .i_Wr_Byte    (wr_byte),
        .o_Full       (full),
        .o_Empty      (empty),
        .o_Count      (count),
        .o_Overflow   (overflow),
        .o_DV         (dv),
        .o_Byte       (obyte),
        .i_Sig_Active (sig_active),
        .i_Sig_Done   (tx_done),
        .o_Busy       (busy)
    );

    // Transmitter model; not affected by rst, like the real transmitter.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        tx_done <= 1'b0;
        dv_prev <= dv;
        if (dv && dv_prev) dv_wide <= dv_wide + 1;
        if (dv && sig_active) dv_busy <= dv_busy + 1;
        if (tx_cnt > 1) begin
            tx_cnt <= tx_cnt - 1;
        end else if (tx_cnt == 1) begin
            tx_cnt    <= 0;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
            done_cyc  <= cyc;
        end else if (dv) begin
            tx_active <= 1'b1;
            tx_cnt    <= FRAME;
            rx_q.push_back(obyte);
            dv_pulses <= dv_pulses + 1;
            last_gap  <= cyc - done_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_one(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_byte = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(empty && !busy && !sig_active && !tx_done) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < TIMEOUT), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp_q [$]);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int         max_cnt;
        int         base;
        int         n;

        // ---------------- Reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_dv",       32'(dv),       32'd0);
        check("rst_byte",     32'(obyte),    32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);

        // ---------------- 1. Single byte ----------------
        rx_q.delete();
        write_one(8'd100);
        check("t1_count_after_wr", 32'(count), 32'd1);
        check("t1_dv_early",       32'(dv),    32'd0);
        @(negedge clk);
        check("t1_dv",      32'(dv),    32'd1);
        check("t1_byte",    32'(obyte), 32'd100);
        check("t1_count0",  32'(count), 32'd0);
        check("t1_busy",    32'(busy),  32'd1);
        @(negedge clk);
        check("t1_dv_fall", 32'(dv),    32'd0);
        check("t1_hold",    32'(obyte), 32'd100);
        wait_idle("t1_idle");
        exp_q = '{8'd100};
        check_rx("t1_rx", exp_q);

        // ---------------- 2. Burst 01..05 ----------------
        rx_q.delete();
        base    = dv_pulses;
        max_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_byte = 8'(i);
            @(negedge clk);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        wr_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        check("t2_peak", 32'(max_cnt), 32'd4);
        wait_idle("t2_idle");
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("t2_rx", exp_q);
        check("t2_pulses", 32'(dv_pulses - base), 32'd5);
        check("t2_gap",    32'(last_gap),         32'd4);

        // ---------------- 3. Full / overflow ----------------
        rx_q.delete();
        hold = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_byte = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 15) begin
                check("t3_full",   32'(full),     32'd1);
                check("t3_count",  32'(count),    32'd16);
                check("t3_no_ovf", 32'(overflow), 32'd0);
            end
            if (i == 16) begin
                check("t3_ovf",        32'(overflow), 32'd1);
                check("t3_count_hold", 32'(count),    32'd16);
            end
        end
        wr_en = 1'b0;
        @(negedge clk);
        check("t3_ovf_clear", 32'(overflow), 32'd0);
        check("t3_no_dv",     32'(dv_pulses > 0 && rx_q.size() > 0), 32'd0);
        hold = 1'b0;
        wait_idle("t3_idle");
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        check_rx("t3_rx", exp_q);

        // ---------------- 4. Pointer wrap ----------------
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            write_one(8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        wait_idle("t4_idle_a");
        for (int i = 0; i < 12; i++) begin
            write_one(8'(8'h60 + i));
            exp_q.push_back(8'(8'h60 + i));
        end
        wait_idle("t4_idle_b");
        check_rx("t4_rx", exp_q);

        // ---------------- 5. Write and pop on the same edge ----------------
        rx_q.delete();
        hold = 1'b1;
        write_one(8'h77);
        check("t5_count1", 32'(count), 32'd1);
        hold    = 1'b0;
        wr_en   = 1'b1;
        wr_byte = 8'h88;
        @(negedge clk);
        wr_en = 1'b0;
        check("t5_count_same", 32'(count), 32'd1);
        check("t5_dv",         32'(dv),    32'd1);
        check("t5_byte",       32'(obyte), 32'h77);
        wait_idle("t5_idle");
        exp_q = '{8'h77, 8'h88};
        check_rx("t5_rx", exp_q);

        // ---------------- 6. Reset mid-frame ----------------
        rx_q.delete();
        base = dv_pulses;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_byte = 8'(8'hC1 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        n = 0;
        while (dv_pulses != base + 2 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("t6_second_frame", 32'(n < TIMEOUT), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_count", 32'(count), 32'd0);
        check("t6_busy",  32'(busy),  32'd0);
        check("t6_dv",    32'(dv),    32'd0);
        write_one(8'hA5);
        check("t6_count_a5", 32'(count), 32'd1);
        check("t6_dv_gated", 32'(dv),    32'd0);
        wait_idle("t6_idle");
        exp_q = '{8'hC1, 8'hC2, 8'hA5};
        check_rx("t6_rx", exp_q);

        // ---------------- Global pulse properties ----------------
        check("dv_width",       32'(dv_wide), 32'd0);
        check("dv_while_active", 32'(dv_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
